// File: rtl/fetch_stage.sv
// Instruction-fetch stage: drives the inst SRAM, holds one instruction for ID,
// buffers SRAM data across ID stalls and remembers redirects that cannot issue yet.
// Optional build macro IF_PERF_CNT_EN adds transfer/cancel performance counters.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h1C000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ID_allow_in,
  input  logic [34:0] ID_br_reg,
  input  logic [32:0] EX_br_reg,
  output logic        inst_sram_en,
  output logic [3:0]  inst_sram_we,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  input  logic [31:0] inst_sram_rdata,
  output logic        IF_to_ID_valid,
  output logic [63:0] IF_ID_reg
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_cancel_cnt
`endif
);

  localparam int unsigned XLEN = 32;

  logic            if_valid_q, if_valid_d;
  logic [XLEN-1:0] if_pc_q, if_pc_d;
  logic            inst_buf_valid_q, inst_buf_valid_d;
  logic [XLEN-1:0] inst_buf_q, inst_buf_d;
  logic            br_pend_valid_q, br_pend_valid_d;
  logic [XLEN-1:0] br_pend_target_q, br_pend_target_d;

  logic            id_taken, ex_taken, redir_taken;
  logic [XLEN-1:0] id_target, ex_target, redir_target;
  logic            if_allow_in, fetch_issue, ex_cancel;
  logic [XLEN-1:0] nextpc, if_inst;

  // Branch-type bits of the ID redirect bus are not needed in this stage.
  logic unused_id_br_type;
  assign unused_id_br_type = |ID_br_reg[34:33];

  // Handshake, next-PC selection and SRAM request.
  always_comb begin
    id_taken     = ID_br_reg[32];
    id_target    = ID_br_reg[31:0];
    ex_taken     = EX_br_reg[32];
    ex_target    = EX_br_reg[31:0];
    redir_taken  = ex_taken | id_taken;
    redir_target = ex_taken ? ex_target : id_target;
    if_allow_in  = !if_valid_q | ID_allow_in;
    fetch_issue  = !reset & if_allow_in;
    ex_cancel    = ex_taken;

    if (ex_taken)             nextpc = ex_target;
    else if (id_taken)        nextpc = id_target;
    else if (br_pend_valid_q) nextpc = br_pend_target_q;
    else                      nextpc = XLEN'(if_pc_q + XLEN'(4));

    if_inst         = inst_buf_valid_q ? inst_buf_q : inst_sram_rdata;
    inst_sram_en    = fetch_issue;
    inst_sram_we    = 4'b0000;
    inst_sram_addr  = nextpc;
    inst_sram_wdata = '0;
    IF_to_ID_valid  = if_valid_q & !ex_cancel;
    IF_ID_reg       = {if_pc_q, if_inst};
  end

  // Next state for the IF slot, instruction buffer and pending redirect.
  always_comb begin
    if_valid_d       = if_valid_q;
    if_pc_d          = if_pc_q;
    inst_buf_valid_d = inst_buf_valid_q;
    inst_buf_d       = inst_buf_q;
    br_pend_valid_d  = br_pend_valid_q;
    br_pend_target_d = br_pend_target_q;

    if (fetch_issue) begin
      if_valid_d       = 1'b1;
      if_pc_d          = nextpc;
      inst_buf_valid_d = 1'b0;
      br_pend_valid_d  = 1'b0;
    end else begin
      if (ex_taken) begin
        // Cancelled instruction: drop it and anything buffered for it.
        if_valid_d       = 1'b0;
        inst_buf_valid_d = 1'b0;
      end else if (if_valid_q && !inst_buf_valid_q && !ID_allow_in) begin
        // SRAM data is only valid for one cycle; keep it while ID stalls.
        inst_buf_valid_d = 1'b1;
        inst_buf_d       = inst_sram_rdata;
      end
      if (redir_taken) begin
        br_pend_valid_d  = 1'b1;
        br_pend_target_d = redir_target;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      if_valid_q       <= 1'b0;
      if_pc_q          <= XLEN'(RESET_PC - XLEN'(4));
      inst_buf_valid_q <= 1'b0;
      inst_buf_q       <= '0;
      br_pend_valid_q  <= 1'b0;
      br_pend_target_q <= '0;
    end else begin
      if_valid_q       <= if_valid_d;
      if_pc_q          <= if_pc_d;
      inst_buf_valid_q <= inst_buf_valid_d;
      inst_buf_q       <= inst_buf_d;
      br_pend_valid_q  <= br_pend_valid_d;
      br_pend_target_q <= br_pend_target_d;
    end
  end

`ifdef IF_PERF_CNT_EN
  logic [XLEN-1:0] perf_fetch_cnt_q, perf_fetch_cnt_d;
  logic [XLEN-1:0] perf_cancel_cnt_q, perf_cancel_cnt_d;

  // Count transfers to ID and EX-cancelled IF instructions.
  always_comb begin
    perf_fetch_cnt_d  = perf_fetch_cnt_q;
    perf_cancel_cnt_d = perf_cancel_cnt_q;
    if (IF_to_ID_valid && ID_allow_in) perf_fetch_cnt_d = XLEN'(perf_fetch_cnt_q + XLEN'(1));
    if (if_valid_q && ex_cancel)       perf_cancel_cnt_d = XLEN'(perf_cancel_cnt_q + XLEN'(1));
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetch_cnt_q  <= '0;
      perf_cancel_cnt_q <= '0;
    end else begin
      perf_fetch_cnt_q  <= perf_fetch_cnt_d;
      perf_cancel_cnt_q <= perf_cancel_cnt_d;
    end
  end

  assign perf_fetch_cnt  = perf_fetch_cnt_q;
  assign perf_cancel_cnt = perf_cancel_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios followed by random traffic, all
// checked against a cycle-level reference model built from the stage's rules.
// The SRAM returns addr+1, so every presented instruction must equal its pc+1.
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h1C000000;

  logic        clk;
  logic        reset;
  logic        ID_allow_in;
  logic [34:0] ID_br_reg;
  logic [32:0] EX_br_reg;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_we;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata;
  logic        IF_to_ID_valid;
  logic [63:0] IF_ID_reg;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_cancel_cnt;
`endif

  fetch_stage #(.RESET_PC(RESET_PC)) u_dut (
    .clk             (clk),
    .reset           (reset),
    .ID_allow_in     (ID_allow_in),
    .ID_br_reg       (ID_br_reg),
    .EX_br_reg       (EX_br_reg),
    .inst_sram_en    (inst_sram_en),
    .inst_sram_we    (inst_sram_we),
    .inst_sram_addr  (inst_sram_addr),
    .inst_sram_wdata (inst_sram_wdata),
    .inst_sram_rdata (inst_sram_rdata),
    .IF_to_ID_valid  (IF_to_ID_valid),
    .IF_ID_reg       (IF_ID_reg)
`ifdef IF_PERF_CNT_EN
    ,
    .perf_fetch_cnt  (perf_fetch_cnt),
    .perf_cancel_cnt (perf_cancel_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous SRAM: addr+1 after an enabled read, junk otherwise.
  always @(posedge clk) begin
    if (inst_sram_en) inst_sram_rdata <= inst_sram_addr + 32'd1;
    else              inst_sram_rdata <= $urandom;
  end

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state.
  bit          m_live;
  logic [31:0] m_pc;
  bit          m_pend;
  logic [31:0] m_ptgt;
  logic [31:0] m_fetch_cnt;
  logic [31:0] m_cancel_cnt;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input bit rst, input bit allow, input bit idtk, input logic [31:0] idtg,
                        input bit extk, input logic [31:0] extg);
    reset       = rst;
    ID_allow_in = allow;
    ID_br_reg   = {2'b00, idtk, idtg};
    EX_br_reg   = {extk, extg};
    #1;
  endtask

  // Check outputs against the model, then advance one clock.
  task automatic cyc();
    bit          ex, id, accept, exp_valid;
    logic [31:0] tgt;
    ex        = EX_br_reg[32];
    id        = ID_br_reg[32];
    accept    = !m_live || ID_allow_in;
    exp_valid = m_live && !ex;
    if (ex)          tgt = EX_br_reg[31:0];
    else if (id)     tgt = ID_br_reg[31:0];
    else if (m_pend) tgt = m_ptgt;
    else             tgt = m_pc + 32'd4;

    check("sram_we", 64'(inst_sram_we), 64'd0);
    check("sram_wdata", 64'(inst_sram_wdata), 64'd0);
    if (reset) begin
      check("en_in_reset", 64'(inst_sram_en), 64'd0);
    end else begin
      check("sram_en", 64'(inst_sram_en), 64'(accept));
      if (accept) check("sram_addr", 64'(inst_sram_addr), 64'(tgt));
      check("if_to_id_valid", 64'(IF_to_ID_valid), 64'(exp_valid));
      if (exp_valid) check("if_id_reg", IF_ID_reg, {m_pc, m_pc + 32'd1});
`ifdef IF_PERF_CNT_EN
      check("perf_fetch_cnt", 64'(perf_fetch_cnt), 64'(m_fetch_cnt));
      check("perf_cancel_cnt", 64'(perf_cancel_cnt), 64'(m_cancel_cnt));
`endif
    end

    @(posedge clk);
    if (reset) begin
      m_live       = 1'b0;
      m_pc         = RESET_PC - 32'd4;
      m_pend       = 1'b0;
      m_ptgt       = '0;
      m_fetch_cnt  = '0;
      m_cancel_cnt = '0;
    end else begin
      if (exp_valid && ID_allow_in) m_fetch_cnt = m_fetch_cnt + 32'd1;
      if (ex && m_live)             m_cancel_cnt = m_cancel_cnt + 32'd1;
      if (accept) begin
        m_pc   = tgt;
        m_live = 1'b1;
        m_pend = 1'b0;
      end else begin
        if (ex) m_live = 1'b0;
        if (ex || id) begin
          m_pend = 1'b1;
          m_ptgt = ex ? EX_br_reg[31:0] : ID_br_reg[31:0];
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input bit allow);
    set_in(1'b0, allow, 1'b0, 32'd0, 1'b0, 32'd0);
  endtask

  task automatic do_reset();
    set_in(1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
    cyc();
  endtask

  // Directed scenarios, then random traffic.
  initial begin
    logic [31:0] cancel0;
    logic [31:0] t_id, t_ex;
    bit          rst, allow, idtk, extk;
    cancel0 = '0;
    m_live = 1'b0; m_pc = '0; m_pend = 1'b0; m_ptgt = '0;
    m_fetch_cnt = '0; m_cancel_cnt = '0;

    // Reset release and sequential fetch, then a 3-cycle ID stall at pc+8.
    do_reset();
    do_reset();
    idle(1'b1);
    check("t1_c0_en", 64'(inst_sram_en), 64'd1);
    check("t1_c0_addr", 64'(inst_sram_addr), 64'h1C000000);
    cyc();
    idle(1'b1);
    check("t1_c1_valid", 64'(IF_to_ID_valid), 64'd1);
    check("t1_c1_reg", IF_ID_reg, {32'h1C000000, 32'h1C000001});
    cyc();
    idle(1'b1);
    check("t1_c2_reg", IF_ID_reg, {32'h1C000004, 32'h1C000005});
    cyc();
    for (int i = 0; i < 3; i++) begin
      idle(1'b0);
      check("t2_stall_valid", 64'(IF_to_ID_valid), 64'd1);
      check("t2_stall_reg", IF_ID_reg, {32'h1C000008, 32'h1C000009});
      check("t2_stall_en", 64'(inst_sram_en), 64'd0);
      cyc();
    end
    idle(1'b1);
    check("t2_rel_reg", IF_ID_reg, {32'h1C000008, 32'h1C000009});
    check("t2_rel_addr", 64'(inst_sram_addr), 64'h1C00000C);
    cyc();
    idle(1'b1);
    check("t2_next_reg", IF_ID_reg, {32'h1C00000C, 32'h1C00000D});
    cyc();

    // ID redirect keeps the delay-slot instruction.
    do_reset();
    idle(1'b1); cyc();
    idle(1'b1); cyc();
    set_in(1'b0, 1'b1, 1'b1, 32'h1C000100, 1'b0, 32'd0);
    check("t3_slot_valid", 64'(IF_to_ID_valid), 64'd1);
    check("t3_slot_reg", IF_ID_reg, {32'h1C000004, 32'h1C000005});
    check("t3_addr", 64'(inst_sram_addr), 64'h1C000100);
    cyc();
    idle(1'b1);
    check("t3_tgt_reg", IF_ID_reg, {32'h1C000100, 32'h1C000101});
    cyc();

    // EX redirect cancels the IF instruction at pc 1C000010.
    do_reset();
    repeat (5) begin idle(1'b1); cyc(); end
    set_in(1'b0, 1'b1, 1'b0, 32'd0, 1'b1, 32'h1C000200);
    check("t4_valid", 64'(IF_to_ID_valid), 64'd0);
    check("t4_en", 64'(inst_sram_en), 64'd1);
    check("t4_addr", 64'(inst_sram_addr), 64'h1C000200);
    cyc();
    idle(1'b1);
    check("t4_tgt_reg", IF_ID_reg, {32'h1C000200, 32'h1C000201});
    cyc();

    // EX redirect during an ID stall becomes pending.
    do_reset();
    idle(1'b1); cyc();
    idle(1'b1); cyc();
    set_in(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'h1C000300);
    check("t5_valid", 64'(IF_to_ID_valid), 64'd0);
    check("t5_en", 64'(inst_sram_en), 64'd0);
    cyc();
    idle(1'b0);
    check("t5_pend_set", 64'(u_dut.br_pend_valid_q), 64'd1);
    check("t5_addr", 64'(inst_sram_addr), 64'h1C000300);
    cyc();
    idle(1'b0);
    check("t5_pend_clr", 64'(u_dut.br_pend_valid_q), 64'd0);
    check("t5_reg", IF_ID_reg, {32'h1C000300, 32'h1C000301});
    cyc();
    idle(1'b1);
    check("t5_rel_addr", 64'(inst_sram_addr), 64'h1C000304);
    cyc();

    // EX and ID redirect together: EX wins.
    do_reset();
    idle(1'b1); cyc();
    idle(1'b1); cyc();
    set_in(1'b0, 1'b1, 1'b1, 32'h1C000500, 1'b1, 32'h1C000400);
`ifdef IF_PERF_CNT_EN
    cancel0 = perf_cancel_cnt;
`endif
    check("t6_addr", 64'(inst_sram_addr), 64'h1C000400);
    cyc();
`ifdef IF_PERF_CNT_EN
    check("t6_cancel_cnt", 64'(perf_cancel_cnt), 64'(cancel0 + 32'd1));
`endif
    idle(1'b1);
    check("t6_reg", IF_ID_reg, {32'h1C000400, 32'h1C000401});
    cyc();

    // Random traffic, including redirects to the top of the address space.
    for (int i = 0; i < 3000; i++) begin
      rst   = ($urandom_range(0, 99) == 0);
      allow = ($urandom_range(0, 9) < 7);
      idtk  = ($urandom_range(0, 9) == 0);
      extk  = ($urandom_range(0, 12) == 0);
      t_id  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
      t_ex  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
      set_in(rst, allow, idtk, t_id, extk, t_ex);
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
